// File: rtl/sk6812_pkg.sv
// Shared definitions for the SK6812 LED chain driver: timing helpers, palette,
// state encoding and word width. Optional feature macro: SK6812_RGBW_EN
// (32-bit GRBW words instead of 24-bit GRB words).
package sk6812_pkg;

`ifdef SK6812_RGBW_EN
  localparam int unsigned WORD_W = 32;
`else
  localparam int unsigned WORD_W = 24;
`endif
  localparam int unsigned BIT_W = $clog2(WORD_W);

  typedef enum logic {
    S_GAP,
    S_BIT
  } state_t;

  // Pulse durations in nanoseconds.
  localparam int unsigned BIT_NS = 1200;
  localparam int unsigned T0H_NS = 300;
  localparam int unsigned T1H_NS = 600;
  localparam int unsigned RST_NS = 80000;

  // round(clk_hz * ns * 1e-9) in 64-bit integer arithmetic.
  function automatic int unsigned cyc_ns(input int unsigned clk_hz, input int unsigned ns);
    return 32'((64'(clk_hz) * 64'(ns) + 64'd500_000_000) / 64'd1_000_000_000);
  endfunction

  localparam int unsigned DEF_CLK_HZ = 50_000_000;
  localparam int unsigned BIT_CYC = cyc_ns(DEF_CLK_HZ, BIT_NS);
  localparam int unsigned T0H_CYC = cyc_ns(DEF_CLK_HZ, T0H_NS);
  localparam int unsigned T1H_CYC = cyc_ns(DEF_CLK_HZ, T1H_NS);
  localparam int unsigned RST_CYC = cyc_ns(DEF_CLK_HZ, RST_NS);

  // Palette entries as GRB.
  localparam logic [23:0] PALETTE [8] = '{
    24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hFFFF00,
    24'hFF00FF, 24'h00FFFF, 24'hFFFFFF, 24'h000000
  };

  // Full serial word for a palette index; white also lights the W channel.
  function automatic logic [WORD_W-1:0] palette_word(input logic [2:0] idx);
`ifdef SK6812_RGBW_EN
    return {PALETTE[idx], (idx == 3'd6) ? 8'hFF : 8'h00};
`else
    return PALETTE[idx];
`endif
  endfunction

endpackage

// File: rtl/sk6812_tx.sv
// Bit serialiser: shapes one SK6812 slot from the selected word bit and the
// slot cycle counter; the pin is driven straight from a flop.
module sk6812_tx
  import sk6812_pkg::*;
#(
  parameter int unsigned CNT_W   = 12,
  parameter int unsigned T0H_LEN = 15,
  parameter int unsigned T1H_LEN = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic [WORD_W-1:0] word,
  input  logic [BIT_W-1:0]  bit_idx,
  input  logic [CNT_W-1:0]  slot_cnt,
  output logic              dout
);

  logic [BIT_W-1:0] sel;
  logic             bit_val;
  logic [CNT_W-1:0] high_len;

  // MSB-first bit select and high-time for the current slot.
  always_comb begin
    sel      = BIT_W'(WORD_W - 1) - bit_idx;
    bit_val  = word[sel];
    high_len = bit_val ? CNT_W'(T1H_LEN) : CNT_W'(T0H_LEN);
  end

  // Registered pin level; high for the leading part of each active slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout <= 1'b0;
    else     dout <= active && (slot_cnt < high_len);
  end

endmodule

// File: rtl/sk6812_led_top.sv
// SK6812 chain driver: walks gap and bit slots, owns LED/frame/step counters
// and the palette lookup, and feeds sk6812_tx. Optional feature macro:
// SK6812_RGBW_EN (32-bit GRBW words).
module sk6812_led_top
  import sk6812_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned NUM_LEDS  = 8,
  parameter int unsigned FRAME_DIV = 64
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic led_dout
);

  localparam int unsigned BIT_LEN = cyc_ns(CLK_HZ, BIT_NS);
  localparam int unsigned T0H_LEN = cyc_ns(CLK_HZ, T0H_NS);
  localparam int unsigned T1H_LEN = cyc_ns(CLK_HZ, T1H_NS);
  localparam int unsigned GAP_LEN = cyc_ns(CLK_HZ, RST_NS);
  localparam int unsigned CNT_MAX = (GAP_LEN > BIT_LEN) ? GAP_LEN : BIT_LEN;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned FRM_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [BIT_W-1:0]  bit_idx, bit_idx_n;
  logic [7:0]        led_idx, led_idx_n;
  logic [FRM_W-1:0]  frame_cnt, frame_cnt_n;
  logic [2:0]        step, step_n;
  logic [WORD_W-1:0] word;

  // Colour of the LED being sent, rotated by the animation step.
  assign word = palette_word(3'(led_idx[2:0] + step));

  // State and counter registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= S_GAP;
      cnt       <= '0;
      bit_idx   <= '0;
      led_idx   <= '0;
      frame_cnt <= '0;
      step      <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      led_idx   <= led_idx_n;
      frame_cnt <= frame_cnt_n;
      step      <= step_n;
    end
  end

  // Next-state: gap countdown, back-to-back bit slots, frame/step advance.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt + CNT_W'(1);
    bit_idx_n   = bit_idx;
    led_idx_n   = led_idx;
    frame_cnt_n = frame_cnt;
    step_n      = step;
    case (state)
      S_GAP: begin
        if (cnt == CNT_W'(GAP_LEN - 1)) begin
          state_n   = S_BIT;
          cnt_n     = '0;
          bit_idx_n = '0;
          led_idx_n = '0;
        end
      end
      S_BIT: begin
        if (cnt == CNT_W'(BIT_LEN - 1)) begin
          cnt_n = '0;
          if (bit_idx == BIT_W'(WORD_W - 1)) begin
            bit_idx_n = '0;
            if (led_idx == 8'(NUM_LEDS - 1)) begin
              state_n   = S_GAP;
              led_idx_n = '0;
              if (frame_cnt == FRM_W'(FRAME_DIV - 1)) begin
                frame_cnt_n = '0;
                step_n      = step + 3'd1;
              end else begin
                frame_cnt_n = frame_cnt + FRM_W'(1);
              end
            end else begin
              led_idx_n = led_idx + 8'd1;
            end
          end else begin
            bit_idx_n = bit_idx + BIT_W'(1);
          end
        end
      end
      default: state_n = S_GAP;
    endcase
  end

  sk6812_tx #(
    .CNT_W  (CNT_W),
    .T0H_LEN(T0H_LEN),
    .T1H_LEN(T1H_LEN)
  ) u_tx (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .active  (state == S_BIT),
    .word    (word),
    .bit_idx (bit_idx),
    .slot_cnt(cnt),
    .dout    (led_dout)
  );

endmodule

// File: tb/tb_sk6812_led_top.sv
// Bench for sk6812_led_top: decodes the serial line by measuring pulse widths
// and compares against a palette/step model. Honours SK6812_RGBW_EN.
module tb_sk6812_led_top;

`ifdef SK6812_RGBW_EN
  localparam int W = 32;
`else
  localparam int W = 24;
`endif
  // Instance A: 50 MHz, 8 LEDs, one frame per step.
  localparam int A_LEDS = 8, A_BIT = 60, A_T0H = 15, A_T1H = 30, A_GAP = 4000, A_THR = 22;
  // Instance B: 10 MHz, 1 LED, two frames per step.
  localparam int B_LEDS = 1, B_DIV = 2, B_BIT = 12, B_GAP = 800, B_THR = 4;

  localparam logic [23:0] PAL [8] = '{
    24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hFFFF00,
    24'hFF00FF, 24'h00FFFF, 24'hFFFFFF, 24'h000000
  };

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic dout_a, dout_b;
  int tests = 0;
  int fails = 0;
  int hi_s [256];
  int lo_s [256];

  always #10 clk = ~clk;

  sk6812_led_top #(.CLK_HZ(50_000_000), .NUM_LEDS(A_LEDS), .FRAME_DIV(1)) dut_a (
    .sys_clk(clk), .sys_rst(rst_a), .led_dout(dout_a));
  sk6812_led_top #(.CLK_HZ(10_000_000), .NUM_LEDS(B_LEDS), .FRAME_DIV(B_DIV)) dut_b (
    .sys_clk(clk), .sys_rst(rst_b), .led_dout(dout_b));

  function automatic logic dout_of(input bit sel);
    return sel ? dout_b : dout_a;
  endfunction

  function automatic logic [31:0] exp_word(input int led, input int step);
    int idx;
    logic [31:0] w;
    idx = (led + step) % 8;
    if (W == 32) w = {PAL[idx], (idx == 6) ? 8'hFF : 8'h00};
    else         w = {8'h00, PAL[idx]};
    return w;
  endfunction

  function automatic logic [31:0] word_at(input int first, input int thr);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < W; b++) w = {w[30:0], (hi_s[first + b] > thr)};
    return w;
  endfunction

  // Starting on a high sample, measure one high run then the following low run.
  task automatic get_slot(input bit sel, output int hi, output int lo, output bit to);
    hi = 0; lo = 0; to = 1'b0;
    while (dout_of(sel) && hi < 200) begin hi++; @(negedge clk); end
    while (!dout_of(sel) && lo < 5000) begin lo++; @(negedge clk); end
    if (hi >= 200 || lo >= 5000) to = 1'b1;
  endtask

  task automatic capture(input bit sel, input int n, output bit to);
    int h, l;
    bit t;
    to = 1'b0;
    for (int i = 0; i < n; i++) begin
      get_slot(sel, h, l, t);
      hi_s[i] = h;
      lo_s[i] = l;
      if (t) begin to = 1'b1; break; end
    end
  endtask

  // Count low samples from the next falling edge until the line rises.
  task automatic count_gap(input bit sel, output int n);
    n = 0;
    @(negedge clk);
    while (!dout_of(sel) && n < 10000) begin n++; @(negedge clk); end
  endtask

  task automatic test_reset;
    int bad, n;
    bad = 0;
    repeat (50) @(negedge clk) if (dout_a !== 1'b0 || dout_b !== 1'b0) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL reset_low: %0d high samples, want 0", bad); end
    rst_a = 1'b0;
    count_gap(1'b0, n);
    tests++;
    if (n != A_GAP) begin fails++; $display("FAIL first_rise: %0d cycles, want %0d", n, A_GAP); end
  endtask

  task automatic test_frame0;
    bit to, e;
    int eh, sum;
    logic [31:0] w0, got;
    capture(1'b0, A_LEDS * W, to);
    tests++;
    if (to) begin fails++; $display("FAIL frame0_timeout: got timeout, want slots"); end
    w0 = exp_word(0, 0);
    for (int s = 0; s < W; s++) begin
      e  = w0[W-1-s];
      eh = e ? A_T1H : A_T0H;
      tests++;
      if (hi_s[s] != eh || lo_s[s] != A_BIT - eh) begin
        fails++;
        $display("FAIL led0_slot%0d: hi=%0d lo=%0d, want hi=%0d lo=%0d", s, hi_s[s], lo_s[s], eh, A_BIT - eh);
      end
    end
    for (int i = 0; i < A_LEDS; i++) begin
      got = word_at(i * W, A_THR);
      tests++;
      if (got !== exp_word(i, 0)) begin
        fails++; $display("FAIL frame0_led%0d: got %h, want %h", i, got, exp_word(i, 0));
      end
    end
    sum = 0;
    for (int s = 0; s < A_LEDS * W; s++) sum += hi_s[s] + lo_s[s];
    tests++;
    if (sum != A_GAP + A_LEDS * W * A_BIT) begin
      fails++; $display("FAIL frame_len: %0d, want %0d", sum, A_GAP + A_LEDS * W * A_BIT);
    end
  endtask

  task automatic test_step;
    bit to;
    logic [31:0] got;
    capture(1'b0, A_LEDS * W, to);
    for (int i = 0; i < A_LEDS; i++) begin
      got = word_at(i * W, A_THR);
      tests++;
      if (to || got !== exp_word(i, 1)) begin
        fails++; $display("FAIL frame1_led%0d: got %h to=%0d, want %h", i, got, to, exp_word(i, 1));
      end
    end
  endtask

  task automatic test_mid_reset;
    bit to;
    int n, k;
    logic [31:0] got;
    k = $urandom_range(1, 40);
    capture(1'b0, k, to);
    tests++;
    if (dout_a !== 1'b1) begin fails++; $display("FAIL pre_reset_high: %b, want 1", dout_a); end
    #($urandom_range(1, 8));
    rst_a = 1'b1;
    #1;
    tests++;
    if (dout_a !== 1'b0) begin fails++; $display("FAIL async_reset: %b, want 0", dout_a); end
    repeat ($urandom_range(2, 10)) @(negedge clk);
    rst_a = 1'b0;
    count_gap(1'b0, n);
    tests++;
    if (n != A_GAP) begin fails++; $display("FAIL regap: %0d cycles, want %0d", n, A_GAP); end
    capture(1'b0, 2 * W, to);
    for (int i = 0; i < 2; i++) begin
      got = word_at(i * W, A_THR);
      tests++;
      if (to || got !== exp_word(i, 0)) begin
        fails++; $display("FAIL restart_led%0d: got %h, want %h", i, got, exp_word(i, 0));
      end
    end
  endtask

  task automatic test_wrap;
    bit to;
    int n, sum, st;
    logic [31:0] got;
    rst_b = 1'b0;
    count_gap(1'b1, n);
    tests++;
    if (n != B_GAP) begin fails++; $display("FAIL b_first_rise: %0d cycles, want %0d", n, B_GAP); end
    for (int f = 0; f <= 8 * B_DIV; f++) begin
      capture(1'b1, B_LEDS * W, to);
      got = word_at(0, B_THR);
      st  = (f / B_DIV) % 8;
      sum = 0;
      for (int s = 0; s < B_LEDS * W; s++) sum += hi_s[s] + lo_s[s];
      tests++;
      if (to || got !== exp_word(0, st) || sum != B_GAP + B_LEDS * W * B_BIT) begin
        fails++;
        $display("FAIL b_frame%0d: got %h len %0d, want %h len %0d", f, got, sum, exp_word(0, st),
                 B_GAP + B_LEDS * W * B_BIT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame0();
    test_step();
    test_mid_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
